traffic_phase_timer: RTL and testbench

// - Phase countdown source for the traffic-light controller: it drives that controller's 3-bit count input and watches its one-hot light output.
// - The controller leaves GREEN at count==2 and leaves YELLOW or RED at count==1.
// - On every light change, this block reloads a per-phase duration and counts down once per prescaled tick.
// - Adds pedestrian green-shortening, run/pause control and light-code error detection.

---
 rtl/traffic_pkg.sv | 14 +
 rtl/traffic_phase_timer_if.sv | 17 +
 rtl/traffic_phase_timer_tick.sv | 25 ++
 rtl/traffic_phase_timer.sv | 64 ++++++
 tb/tb_traffic_phase_timer.sv | 149 ++++++++++++++
 5 files changed

// File: rtl/traffic_pkg.sv
// traffic_pkg: light codes, terminal counts and default phase loads shared by the traffic blocks
package traffic_pkg;
    localparam logic [2:0] GREEN_OUT  = 3'd1;
    localparam logic [2:0] YELLOW_OUT = 3'd2;
    localparam logic [2:0] RED_OUT    = 3'd4;
    localparam logic [2:0] GREEN_EXIT = 3'd2;
    localparam logic [2:0] PHASE_EXIT = 3'd1;
    localparam int         DEF_CLK_DIV     = 50_000_000;
    localparam logic [2:0] DEF_GREEN_LOAD  = 3'd7;
    localparam logic [2:0] DEF_YELLOW_LOAD = 3'd3;
    localparam logic [2:0] DEF_RED_LOAD    = 3'd6;
    localparam logic [2:0] DEF_PED_CUT     = 3'd3;
    localparam logic [2:0] RESET_COUNT     = 3'd7;
endpackage

// File: rtl/traffic_phase_timer_if.sv
// traffic_phase_timer_if: light/control inputs and countdown outputs between controller side (master) and timer (slave)
//   lightIn   light code from the controller (1 green, 2 yellow, 4 red)
//   run       1 = countdown advances, 0 = frozen
//   pedReq    pedestrian request level
//   count     countdown value back to the controller
//   phaseDone one-cycle pulse on a new-phase reload
//   lightErr  sticky illegal-light-code flag
interface traffic_phase_timer_if;
    logic [2:0] lightIn;
    logic       run;
    logic       pedReq;
    logic [2:0] count;
    logic       phaseDone;
    logic       lightErr;
    modport master (output lightIn, run, pedReq, input count, phaseDone, lightErr);
    modport slave  (input lightIn, run, pedReq, output count, phaseDone, lightErr);
endinterface

// File: rtl/traffic_phase_timer_tick.sv
// tick_gen: CLK_DIV prescaler producing one tick per CLK_DIV enabled clk cycles
//   clk, rst  clock and asynchronous active-high reset
//   en        advance the prescaler
//   clr       restart the prescaler at 0 (wins over en)
//   tick      high while the prescaler sits at CLK_DIV-1
module tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int W = $clog2(CLK_DIV);
    logic [W-1:0] cnt;
    assign tick = cnt == W'(CLK_DIV - 1);
    always_ff @(posedge clk or posedge rst)
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= tick ? '0 : cnt + W'(1);
endmodule

// File: rtl/traffic_phase_timer.sv
// traffic_phase_timer: per-phase countdown for the traffic-light controller with pedestrian cut, pause and light-code checking
//   clk, rst  clock and asynchronous active-high reset
//   bus       slave side of traffic_phase_timer_if (lightIn/run/pedReq in, count/phaseDone/lightErr out)
module traffic_phase_timer
    import traffic_pkg::*;
#(
    parameter int         CLK_DIV     = DEF_CLK_DIV,
    parameter logic [2:0] GREEN_LOAD  = DEF_GREEN_LOAD,
    parameter logic [2:0] YELLOW_LOAD = DEF_YELLOW_LOAD,
    parameter logic [2:0] RED_LOAD    = DEF_RED_LOAD,
    parameter logic [2:0] PED_CUT     = DEF_PED_CUT
) (
    input logic                  clk,
    input logic                  rst,
    traffic_phase_timer_if.slave bus
);
    logic [2:0] light_prev;
    logic [2:0] load_val;
    logic [2:0] floor_val;
    logic [2:0] count_next;
    logic       green;
    logic       legal;
    logic       err;
    logic       reload;
    logic       ped;
    logic       dec;
    logic       tick;

    tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (bus.run && !err),
        .clr  (reload || ped),
        .tick (tick)
    );

    // Priority chain: error freezes everything, then reload, pedestrian cut, tick decrement.
    always_comb begin
        green      = bus.lightIn == GREEN_OUT;
        legal      = green || bus.lightIn == YELLOW_OUT || bus.lightIn == RED_OUT;
        err        = bus.lightErr || !legal;
        reload     = !err && bus.lightIn != light_prev;
        load_val   = green ? GREEN_LOAD : bus.lightIn == YELLOW_OUT ? YELLOW_LOAD : RED_LOAD;
        floor_val  = green ? GREEN_EXIT : PHASE_EXIT;
        ped        = !err && !reload && green && bus.pedReq && bus.count > PED_CUT;
        dec        = !err && !reload && !ped && bus.run && tick && bus.count > floor_val;
        count_next = reload ? load_val : ped ? PED_CUT : dec ? bus.count - 3'd1 : bus.count;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            bus.count     <= RESET_COUNT;
            bus.phaseDone <= 1'b0;
            bus.lightErr  <= 1'b0;
            light_prev    <= 3'b000;
        end else begin
            bus.count     <= count_next;
            bus.lightErr  <= err;
            // The first reload after reset is not a phase change.
            bus.phaseDone <= reload && light_prev != 3'b000;
            if (!err)
                light_prev <= bus.lightIn;
        end
endmodule

// File: tb/tb_traffic_phase_timer.sv
// tb_traffic_phase_timer: randomized scoreboard bench for traffic_phase_timer against a behavioural phase model
module tb_traffic_phase_timer;
    localparam int DIV = 4;

    typedef struct {
        int count;
        int done;
        int err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    traffic_phase_timer_if bus ();

    traffic_phase_timer #(.CLK_DIV(DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    int m_prev, m_err, m_count, m_pre;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int load_of(input int li);
        return li == 1 ? 7 : li == 2 ? 3 : 6;
    endfunction

    task automatic model_reset();
        m_prev = 0;
        m_err = 0;
        m_count = 7;
        m_pre = 0;
    endtask

    // One clk of phase behaviour; returns expected phaseDone for that clk.
    task automatic model_step(input int li, input int rn, input int pd, output exp_t e);
        int done = 0;
        if (m_err != 0 || !(li == 1 || li == 2 || li == 4)) begin
            m_err = 1;
        end else begin
            if (li != m_prev) begin
                m_count = load_of(li);
                done = m_prev != 0;
                m_pre = 0;
            end else if (li == 1 && pd != 0 && m_count > 3) begin
                m_count = 3;
                m_pre = 0;
            end else if (rn != 0) begin
                if (m_pre == DIV - 1 && m_count > (li == 1 ? 2 : 1))
                    m_count--;
                m_pre = (m_pre + 1) % DIV;
            end
            m_prev = li;
        end
        e.count = m_count;
        e.done = done;
        e.err = m_err;
    endtask

    // Drive one clk worth of inputs at the current negedge and queue the expected outcome.
    task automatic cycle(input int li, input int rn, input int pd);
        exp_t e;
        bus.lightIn = 3'(li);
        bus.run = rn[0];
        bus.pedReq = pd[0];
        model_step(li, rn, pd, e);
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("reset_count", int'(bus.count), 7);
        chk("reset_done", int'(bus.phaseDone), 0);
        chk("reset_err", int'(bus.lightErr), 0);
        model_reset();
        #1 rst = 1'b0;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("count", int'(bus.count), e.count);
                chk("phaseDone", int'(bus.phaseDone), e.done);
                chk("lightErr", int'(bus.lightErr), e.err);
                if (bus.count == 3'd0)
                    chk("count_nonzero", int'(bus.count), 1);
            end
        end
    end

    initial begin
        int order[3] = '{4, 1, 2};
        int bad[5] = '{0, 3, 5, 6, 7};
        int idx, li, dur, rmode, rn;
        bus.lightIn = 3'd4;
        bus.run = 1'b1;
        bus.pedReq = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset();
        // Directed opener: red countdown to floor and hold, then green to its floor.
        repeat (40) cycle(4, 1, 0);
        repeat (40) cycle(1, 1, 0);
        repeat (3) cycle(1, 1, 0);
        for (int r = 0; r < 4; r++) begin
            if (r != 0)
                do_reset();
            idx = 0;
            for (int s = 0; s < 50; s++) begin
                li = ($urandom_range(0, 7) == 0) ? order[$urandom_range(0, 2)] : order[idx];
                idx = (idx + 1) % 3;
                dur = $urandom_range(1, 30);
                rmode = $urandom_range(0, 3);
                for (int c = 0; c < dur; c++) begin
                    rn = (rmode == 0) ? int'($urandom_range(0, 1)) : (rmode == 1 && c < 12) ? 0 : 1;
                    cycle(li, rn, ($urandom_range(0, 7) == 0) ? 1 : 0);
                end
            end
            // Inject an illegal code, then show that legal codes do not clear the flag.
            cycle(bad[$urandom_range(0, 4)], 1, 0);
            for (int c = 0; c < 12; c++)
                cycle(order[$urandom_range(0, 2)], 1, int'($urandom_range(0, 1)));
        end
        @(posedge clk);
        #2;
        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
